// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: data width plus write-arbiter state type and limits.
package FIFO_pkg;

   localparam int unsigned FIFO_WIDTH      = 32;
   localparam int unsigned ARB_NUM_REQ_MAX = 8;

   typedef enum logic {
      ARB_IDLE,
      ARB_BURST
   } arb_state_e;

endpackage

// File: rtl/fifo_rr_picker.sv
// Combinational round-robin picker: first set request scanning upward from start, with wrap.
module fifo_rr_picker #(
   parameter int unsigned NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0]         req,
   input  logic [$clog2(NUM_REQ)-1:0] start,
   output logic                       found,
   output logic [$clog2(NUM_REQ)-1:0] index
);

   localparam int unsigned IDX_W = $clog2(NUM_REQ);

   always_comb begin
      found = 1'b0;
      index = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         if (!found && req[(32'(start) + k) % NUM_REQ]) begin
            found = 1'b1;
            index = IDX_W'((32'(start) + k) % NUM_REQ);
         end
      end
   end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Burst-limited round-robin arbiter for the async FIFO write port.
// Optional FIFO_ARB_STATS_EN adds saturating grant/stall statistics outputs.
module fifo_write_arbiter
   import FIFO_pkg::*;
#(
   parameter int unsigned NUM_REQ   = 4,
   parameter int unsigned MAX_BURST = 4,
   parameter int unsigned CNT_W     = 16
) (
   input  logic                          wclk,
   input  logic                          wrst,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
   input  logic                          full,
   output logic [NUM_REQ-1:0]            gnt,
   output logic                          w_en,
   output logic [FIFO_WIDTH-1:0]         data_in,
   output logic                          busy,
   output logic [$clog2(NUM_REQ)-1:0]    owner_id
`ifdef FIFO_ARB_STATS_EN
   ,
   output logic [NUM_REQ*CNT_W-1:0]      grant_cnt,
   output logic [CNT_W-1:0]              stall_cnt
`endif
);

   localparam int unsigned IDX_W  = $clog2(NUM_REQ);
   localparam int unsigned BEAT_W = $clog2(MAX_BURST + 1);

   arb_state_e        state_q, state_d;
   logic [IDX_W-1:0]  owner_q, owner_d;
   logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic [BEAT_W-1:0] beat_q, beat_d;

   logic              grant_ok, release_own, pick_found;
   logic [IDX_W-1:0]  pick_base, pick_start, pick_idx;

   // IDLE scans after the last owner; a release scans after the current owner.
   assign pick_base  = (state_q == ARB_IDLE) ? rr_ptr_q : owner_q;
   assign pick_start = (pick_base == IDX_W'(NUM_REQ - 1)) ? '0 : pick_base + 1'b1;

   fifo_rr_picker #(
      .NUM_REQ (NUM_REQ)
   ) u_picker (
      .req   (req),
      .start (pick_start),
      .found (pick_found),
      .index (pick_idx)
   );

   assign grant_ok    = (state_q == ARB_BURST) && req[owner_q] && !full;
   assign release_own = (grant_ok && (beat_q == BEAT_W'(MAX_BURST - 1))) ||
                        ((state_q == ARB_BURST) && !req[owner_q]);

   always_comb begin
      gnt          = '0;
      gnt[owner_q] = grant_ok;
   end

   assign w_en     = grant_ok;
   assign data_in  = grant_ok ? req_data[int'(owner_q)*FIFO_WIDTH +: FIFO_WIDTH] : '0;
   assign busy     = (state_q != ARB_IDLE);
   assign owner_id = owner_q;

   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      rr_ptr_d = rr_ptr_q;
      beat_d   = beat_q;
      unique case (state_q)
         ARB_IDLE: begin
            if (pick_found) begin
               owner_d = pick_idx;
               beat_d  = '0;
               state_d = ARB_BURST;
            end
         end
         ARB_BURST: begin
            if (release_own) begin
               rr_ptr_d = owner_q;
               beat_d   = '0;
               if (pick_found) begin
                  owner_d = pick_idx;
               end else begin
                  owner_d = '0;
                  state_d = ARB_IDLE;
               end
            end else if (grant_ok) begin
               beat_d = beat_q + 1'b1;
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge wclk or posedge wrst) begin
      if (wrst) begin
         state_q  <= ARB_IDLE;
         owner_q  <= '0;
         rr_ptr_q <= IDX_W'(NUM_REQ - 1);
         beat_q   <= '0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         rr_ptr_q <= rr_ptr_d;
         beat_q   <= beat_d;
      end
   end

`ifdef FIFO_ARB_STATS_EN
   always_ff @(posedge wclk or posedge wrst) begin
      if (wrst) begin
         grant_cnt <= '0;
         stall_cnt <= '0;
      end else begin
         for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gnt[i] && (grant_cnt[i*CNT_W +: CNT_W] != '1)) begin
               grant_cnt[i*CNT_W +: CNT_W] <= grant_cnt[i*CNT_W +: CNT_W] + 1'b1;
            end
         end
         if ((state_q == ARB_BURST) && req[owner_q] && full && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed self-checking bench for fifo_write_arbiter (default configuration).
module tb_fifo_write_arbiter;
   import FIFO_pkg::*;

   localparam int unsigned N = 4;
   localparam logic [31:0] BASE = 32'hA5A5_0000;

   logic                   wclk = 1'b0;
   logic                   wrst = 1'b0;
   logic [N-1:0]           req  = '0;
   logic [N*FIFO_WIDTH-1:0] req_data;
   logic                   full = 1'b0;
   logic [N-1:0]           gnt;
   logic                   w_en;
   logic [FIFO_WIDTH-1:0]  data_in;
   logic                   busy;
   logic [1:0]             owner_id;
`ifdef FIFO_ARB_STATS_EN
   logic [N*16-1:0]        grant_cnt;
   logic [15:0]            stall_cnt;
`endif

   int vectors     = 0;
   int miscompares = 0;

   fifo_write_arbiter #(
      .NUM_REQ   (N),
      .MAX_BURST (4),
      .CNT_W     (16)
   ) dut (
      .wclk      (wclk),
      .wrst      (wrst),
      .req       (req),
      .req_data  (req_data),
      .full      (full),
      .gnt       (gnt),
      .w_en      (w_en),
      .data_in   (data_in),
      .busy      (busy),
      .owner_id  (owner_id)
`ifdef FIFO_ARB_STATS_EN
      ,
      .grant_cnt (grant_cnt),
      .stall_cnt (stall_cnt)
`endif
   );

   always #5 wclk = ~wclk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Outputs sampled 2 time units after inputs change, well away from the posedge.
   task automatic chk_out(input string tag, input logic [3:0] g, input logic [31:0] d,
                          input logic b, input logic [1:0] o);
      #2;
      check({tag, "_gnt"}, 32'(gnt), 32'(g));
      check({tag, "_wen"}, 32'(w_en), 32'(|g));
      check({tag, "_data"}, data_in, d);
      check({tag, "_busy"}, 32'(busy), 32'(b));
      check({tag, "_owner"}, 32'(owner_id), 32'(o));
   endtask

   task automatic tick();
      @(posedge wclk);
      #1;
   endtask

   task automatic do_reset();
      wrst = 1'b1;
      req  = '0;
      full = 1'b0;
      tick();
      tick();
      wrst = 1'b0;
   endtask

   task automatic chk_owner(input string tag, input int o);
      chk_out(tag, 4'(1 << o), BASE + 32'(o), 1'b1, 2'(o));
      tick();
   endtask

   initial begin
      for (int i = 0; i < N; i++) req_data[i*FIFO_WIDTH +: FIFO_WIDTH] = BASE + 32'(i);
      #1;

      // Reset holds all outputs low even with every request asserted.
      wrst = 1'b1;
      req  = 4'hF;
      for (int i = 0; i < 3; i++) begin
         chk_out("rst", 4'b0, 32'h0, 1'b0, 2'd0);
         tick();
      end
      wrst = 1'b0;

      // Sole requester: one idle cycle, then back-to-back self re-grants.
      do_reset();
      req = 4'b0001;
      chk_out("solo_idle", 4'b0, 32'h0, 1'b0, 2'd0);
      tick();
      for (int k = 0; k < 10; k++) chk_owner("solo", 0);

      // All requesting: exactly four beats each in rotation.
      do_reset();
      req = 4'hF;
      chk_out("rr_idle", 4'b0, 32'h0, 1'b0, 2'd0);
      tick();
      for (int k = 0; k < 20; k++) chk_owner("rr", (k / 4) % 4);

      // Stall mid-burst: owner 2 holds through full, finishes, then owner 3.
      do_reset();
      req = 4'b1100;
      chk_out("stall_idle", 4'b0, 32'h0, 1'b0, 2'd0);
      tick();
      chk_owner("stall_pre", 2);
      chk_owner("stall_pre", 2);
      full = 1'b1;
      for (int k = 0; k < 5; k++) begin
         chk_out("stall_full", 4'b0, 32'h0, 1'b1, 2'd2);
         tick();
      end
      full = 1'b0;
      chk_owner("stall_post", 2);
      chk_owner("stall_post", 2);
      chk_owner("stall_next", 3);

      // Owner drops request: ownership passes next cycle without idling.
      do_reset();
      req = 4'b1010;
      chk_out("drop_idle", 4'b0, 32'h0, 1'b0, 2'd0);
      tick();
      chk_owner("drop_first", 1);
      req = 4'b1000;
      chk_out("drop_gap", 4'b0, 32'h0, 1'b1, 2'd1);
      tick();
      chk_owner("drop_next", 3);

      // Reset mid-burst clears outputs immediately; requester 0 wins afterwards.
      do_reset();
      req = 4'b1000;
      chk_out("mid_idle", 4'b0, 32'h0, 1'b0, 2'd0);
      tick();
      chk_owner("mid_burst", 3);
      chk_out("mid_burst2", 4'b1000, BASE + 32'd3, 1'b1, 2'd3);
      wrst = 1'b1;
      chk_out("mid_rst", 4'b0, 32'h0, 1'b0, 2'd0);
      tick();
      wrst = 1'b0;
      req  = 4'hF;
      chk_out("after_idle", 4'b0, 32'h0, 1'b0, 2'd0);
      tick();
      chk_owner("after_first", 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
